// File: rtl/mash_acc_pair_pkg.sv
// rtl/mash_acc_pair_pkg.sv - shared MASH constants: FSM encoding, fill length, carry output type
package mash_acc_pair_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam int FILL_LEN = 2;

    typedef logic signed [3:0] carry_t;

    // Carries are 0 or 1, so extension into the 4-bit signed type never sets the sign bit.
    function automatic carry_t carry_ext(input logic c);
        return carry_t'({3'b000, c});
    endfunction

endpackage

// File: rtl/mash_acc_stage.sv
// rtl/mash_acc_stage.sv - single first-order accumulator stage with carry out
module mash_acc_stage #(
    parameter int W = 16
) (
    input  logic         clck,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] a,
    output logic [W-1:0] s,
    output logic         c
);

    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n) begin
            s <= '0;
            c <= 1'b0;
        end else if (clr) begin
            s <= '0;
            c <= 1'b0;
        end else if (en) begin
            {c, s} <= {1'b0, s} + {1'b0, a};
        end
    end

endmodule

// File: rtl/mash_acc_pair.sv
// rtl/mash_acc_pair.sv - two-stage MASH accumulator pair with pending input register and fill FSM
module mash_acc_pair
    import mash_acc_pair_pkg::*;
#(
    parameter int ACC_W = 16
) (
    input  logic              clck,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              clr,
    input  logic [ACC_W-1:0]  din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic signed [3:0] c1_out,
    output logic signed [3:0] c2_out,
    output logic              out_valid
);

    logic [ACC_W-1:0] pend;
    logic             pend_full;
    logic [ACC_W-1:0] xa;
    logic [ACC_W-1:0] s1;
    logic [ACC_W-1:0] s2;
    logic             c1;
    logic             c2;
    logic             c1_d;
    logic [1:0]       state;
    logic [1:0]       fill_cnt;
    logic             adv;
    logic             hs;
    logic             consume;

    assign adv       = tick && !clr;
    // A clear drops any handshake in the same cycle, even with the pending slot empty.
    assign din_ready = !clr && (!pend_full || tick);
    assign hs        = din_valid && din_ready;
    assign consume   = adv && pend_full;

    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n) begin
            pend      <= '0;
            pend_full <= 1'b0;
            xa        <= '0;
        end else begin
            if (hs)
                pend <= din;
            if (clr) begin
                pend_full <= 1'b0;
                xa        <= '0;
            end else begin
                if (hs)
                    pend_full <= 1'b1;
                else if (consume)
                    pend_full <= 1'b0;
                if (consume)
                    xa <= pend;
            end
        end
    end

    // Stage 2 sees s1 before this tick's update because both stages register on the same edge.
    mash_acc_stage #(.W(ACC_W)) u_stage1 (
        .clck  (clck),
        .rst_n (rst_n),
        .en    (adv),
        .clr   (clr),
        .a     (xa),
        .s     (s1),
        .c     (c1)
    );

    mash_acc_stage #(.W(ACC_W)) u_stage2 (
        .clck  (clck),
        .rst_n (rst_n),
        .en    (adv),
        .clr   (clr),
        .a     (s1),
        .s     (s2),
        .c     (c2)
    );

    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n) begin
            c1_d     <= 1'b0;
            state    <= ST_IDLE;
            fill_cnt <= '0;
        end else if (clr) begin
            c1_d     <= 1'b0;
            state    <= ST_IDLE;
            fill_cnt <= '0;
        end else if (adv) begin
            c1_d <= c1;
            case (state)
                ST_IDLE: begin
                    if (pend_full) begin
                        state    <= ST_FILL;
                        fill_cnt <= '0;
                    end
                end
                ST_FILL: begin
                    if (fill_cnt == 2'(FILL_LEN - 1))
                        state <= ST_RUN;
                    else
                        fill_cnt <= fill_cnt + 2'd1;
                end
                ST_RUN:  state <= ST_RUN;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = (state == ST_RUN);
    assign c1_out    = carry_ext(c1_d);
    assign c2_out    = carry_ext(c2);

endmodule
